// File: rtl/pwm_fader_pkg.sv
// Shared definitions for the pwm_fader block: channel mode encoding and
// the PWM period helper.
package pwm_fader_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_STATIC  = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_RAMP    = 2'd3
  } mode_e;

  // PWM period length in cycles for a given counter width.
  function automatic int maxv(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/pwm_fader_chan.sv
// One PWM channel: pending (write) and active settings, fade level and
// direction, and the duty compare against the shared period counter.
//   clk, rst      clock, synchronous active-high reset
//   wr            write strobe for this channel (pending <= mode/limit)
//   mode, limit   write data
//   boundary      last cycle of the period; active settings update here
//   step          boundary with a pending fade tick; fade engine advances
//   cnt           shared period counter
//   pwm_on        combinational on/off for this cycle (top registers it)
module pwm_fader_chan import pwm_fader_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] limit,
  input  logic             boundary,
  input  logic             step,
  input  logic [WIDTH-1:0] cnt,
  output logic             pwm_on
);

  mode_e            pend_mode, act_mode, nxt_mode;
  logic [WIDTH-1:0] pend_limit, act_limit, nxt_limit;
  logic [WIDTH-1:0] level, a_level, s_level, duty;
  logic             dir_down, a_down, s_down;

  always_comb begin
    // A write in the boundary cycle itself must land in this update.
    nxt_mode  = wr ? mode_e'(mode) : pend_mode;
    nxt_limit = wr ? limit : pend_limit;

    // Apply settings first.
    a_level = level;
    a_down  = dir_down;
    if (nxt_mode == MODE_OFF || nxt_mode == MODE_STATIC) begin
      a_level = '0;
      a_down  = 1'b0;
    end else if (nxt_mode != act_mode) begin
      a_level = '0;
      a_down  = 1'b0;
    end else if (nxt_limit < level) begin
      a_level = nxt_limit;
      a_down  = (nxt_mode == MODE_BREATHE);
    end

    // Then step using the freshly applied limit and level.
    s_level = a_level;
    s_down  = a_down;
    if (step) begin
      if (nxt_mode == MODE_BREATHE) begin
        if (!a_down && a_level < nxt_limit) begin
          s_level = a_level + 1'b1;
          s_down  = ((a_level + 1'b1) == nxt_limit);
        end else if (a_level != '0) begin
          // Falling edge of the triangle (or turnaround at the peak).
          s_level = a_level - 1'b1;
          s_down  = (a_level != WIDTH'(1));
        end else begin
          s_down  = 1'b0;
        end
      end else if (nxt_mode == MODE_RAMP) begin
        if (a_level < nxt_limit) s_level = a_level + 1'b1;
      end
    end
  end

  assign duty   = (act_mode == MODE_STATIC) ? act_limit : level;
  assign pwm_on = (act_mode != MODE_OFF) && (cnt < duty);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_mode  <= MODE_OFF;
      pend_limit <= '0;
      act_mode   <= MODE_OFF;
      act_limit  <= '0;
      level      <= '0;
      dir_down   <= 1'b0;
    end else begin
      if (wr) begin
        pend_mode  <= mode_e'(mode);
        pend_limit <= limit;
      end
      if (boundary) begin
        act_mode  <= nxt_mode;
        act_limit <= nxt_limit;
        level     <= s_level;
        dir_down  <= s_down;
      end
    end
  end

endmodule

// File: rtl/pwm_fader.sv
// Multi-channel PWM LED driver with per-channel OFF/STATIC/BREATHE/RAMP
// fade engine. Settings are double-buffered and take effect only at period
// boundaries so outputs never glitch mid-period.
//   clk, rst      clock, synchronous active-high reset
//   wr_en         one-cycle write strobe
//   wr_chan       target channel (values >= CHANNELS are ignored)
//   wr_mode       0 OFF, 1 STATIC, 2 BREATHE, 3 RAMP
//   wr_limit      STATIC duty / BREATHE,RAMP peak
//   fade_div      fade step interval in cycles minus one (sampled live)
//   pwm_out       registered PWM outputs, inverted when ACTIVE_LOW
//   period_start  registered pulse in the first cycle of each period
module pwm_fader import pwm_fader_pkg::*; #(
  parameter int CHANNELS   = 3,
  parameter int WIDTH      = 8,
  parameter int DIV_W      = 18,
  parameter int ACTIVE_LOW = 1,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_chan,
  input  logic [1:0]          wr_mode,
  input  logic [WIDTH-1:0]    wr_limit,
  input  logic [DIV_W-1:0]    fade_div,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_start
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(maxv(WIDTH) - 1);

  logic [WIDTH-1:0]    cnt;
  logic [DIV_W-1:0]    prescaler;
  logic                tick, boundary, step;
  logic [CHANNELS-1:0] wr_sel, on;

  assign boundary = (cnt == LAST);
  assign step     = boundary && tick;

  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < CHANNELS; i++)
      wr_sel[i] = wr_en && (wr_chan == CH_W'(i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      prescaler    <= '0;
      tick         <= 1'b0;
      period_start <= 1'b0;
      pwm_out      <= (ACTIVE_LOW != 0) ? '1 : '0;
    end else begin
      cnt <= boundary ? '0 : cnt + 1'b1;
      // '>=' keeps the prescaler sane if fade_div is lowered on the fly.
      // A wrap landing on the consuming boundary re-arms the tick.
      if (prescaler >= fade_div) begin
        prescaler <= '0;
        tick      <= 1'b1;
      end else begin
        prescaler <= prescaler + 1'b1;
        if (boundary) tick <= 1'b0;
      end
      period_start <= (cnt == '0);
      pwm_out      <= (ACTIVE_LOW != 0) ? ~on : on;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    pwm_fader_chan #(.WIDTH(WIDTH)) u_chan (
      .clk      (clk),
      .rst      (rst),
      .wr       (wr_sel[i]),
      .mode     (wr_mode),
      .limit    (wr_limit),
      .boundary (boundary),
      .step     (step),
      .cnt      (cnt),
      .pwm_on   (on[i])
    );
  end

endmodule
